// File: rtl/note_glyph_blitter.sv
// note_glyph_blitter
//   Copies one 8x8 note/rest glyph from note_rom into the staff frame buffer,
//   one pixel per DRAW cycle, at a commanded (x, y). Off-screen pixels are
//   clipped. Frame-buffer backpressure stalls the current pixel.
//
// Configuration macro:
//   NOTE_BLIT_OPAQUE_EN  defined   : clear bits of visible pixels write cmd_bg
//                        undefined : transparent, clear bits never write
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   draw-command handshake (one command at a time)
//   cmd_code/x/y/fg/bg    glyph code, top-left position, colours
//   rom_addr/rom_data     note_rom read port ({code, row}, combinational data)
//   fb_we/addr/data       frame-buffer write port, fb_ready accepts a write
//   busy                  high whenever not idle
//   done                  one-cycle pulse when the glyph is complete
//
// fb_addr is built as shifts and adds of SCREEN_W; SCREEN_W and SCREEN_H must
// fit in 11 bits and FB_ADDR_W must be at least 11.
module note_glyph_blitter #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int FB_ADDR_W = 19,
  parameter int COLOR_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_code,
  input  logic [9:0]           cmd_x,
  input  logic [9:0]           cmd_y,
  input  logic [COLOR_W-1:0]   cmd_fg,
  input  logic [COLOR_W-1:0]   cmd_bg,
  output logic [5:0]           rom_addr,
  input  logic [7:0]           rom_data,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data,
  input  logic                 fb_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAW, S_DONE} state_e;

  localparam logic [10:0] SCREEN_W_11 = 11'(SCREEN_W);
  localparam logic [10:0] SCREEN_H_11 = 11'(SCREEN_H);

  state_e               state_q;
  logic [2:0]           code_q;
  logic [2:0]           row_q;
  logic [2:0]           col_q;
  logic [9:0]           x_q;
  logic [9:0]           y_q;
  logic [COLOR_W-1:0]   fg_q;
  logic [7:0]           bits_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 fb_we_q;
  logic [5:0]           rom_addr_q;
  logic [FB_ADDR_W-1:0] fb_addr_q;
  logic [COLOR_W-1:0]   fb_data_q;

  // Evaluation of the pixel that the next DRAW cycle will present: column 0
  // of the row arriving from the ROM (in FETCH), or the next column of the
  // row register (in DRAW).
  logic [7:0]           nxt_bits;
  logic [2:0]           nxt_col;
  logic [10:0]          nxt_px;
  logic [10:0]          nxt_py;
  logic                 nxt_bit;
  logic                 nxt_vis;
  logic                 nxt_we;
  logic [FB_ADDR_W-1:0] nxt_addr;
  logic [COLOR_W-1:0]   nxt_data;

  // NOTE: every variable gets an unconditional value first so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    nxt_bits = (state_q == S_FETCH) ? rom_data : bits_q;
    nxt_col  = (state_q == S_FETCH) ? 3'd0 : col_q + 3'd1;
    // 11-bit sums so 1023 + 7 lands past the screen instead of wrapping.
    nxt_px   = {1'b0, x_q} + {8'd0, nxt_col};
    nxt_py   = {1'b0, y_q} + {8'd0, row_q};
    nxt_bit  = nxt_bits[3'd7 - nxt_col];
    nxt_vis  = (nxt_px < SCREEN_W_11) && (nxt_py < SCREEN_H_11);
    // py*SCREEN_W + px as a sum of shifted copies of py, one per set bit of
    // the pitch; the fixed width performs the truncation.
    nxt_addr = {{(FB_ADDR_W-11){1'b0}}, nxt_px};
    for (int i = 0; i < 11; i++) begin
      if (SCREEN_W_11[i]) begin
        nxt_addr = nxt_addr + ({{(FB_ADDR_W-11){1'b0}}, nxt_py} << i);
      end
    end
  end

`ifdef NOTE_BLIT_OPAQUE_EN
  logic [COLOR_W-1:0] bg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bg_q <= '0;
    end else if (state_q == S_IDLE && cmd_valid) begin
      bg_q <= cmd_bg;
    end
  end

  assign nxt_we   = nxt_vis;
  assign nxt_data = nxt_bit ? fg_q : bg_q;
`else
  // Transparent mode never looks at the background colour.
  logic unused_bg;
  assign unused_bg = ^cmd_bg;

  assign nxt_we   = nxt_vis & nxt_bit;
  assign nxt_data = fg_q;
`endif

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      fg_q       <= '0;
      bits_q     <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fb_we_q    <= 1'b0;
      rom_addr_q <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            code_q     <= cmd_code;
            x_q        <= cmd_x;
            y_q        <= cmd_y;
            fg_q       <= cmd_fg;
            row_q      <= 3'd0;
            rom_addr_q <= {cmd_code, 3'd0};
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          bits_q    <= rom_data;
          col_q     <= 3'd0;
          fb_we_q   <= nxt_we;
          fb_addr_q <= nxt_addr;
          fb_data_q <= nxt_data;
          state_q   <= S_DRAW;
        end
        S_DRAW: begin
          // A pending write that the frame buffer refuses holds everything.
          if (!fb_we_q || fb_ready) begin
            if (col_q == 3'd7) begin
              fb_we_q <= 1'b0;
              if (row_q == 3'd7) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                row_q      <= row_q + 3'd1;
                rom_addr_q <= {code_q, row_q + 3'd1};
                state_q    <= S_FETCH;
              end
            end else begin
              col_q     <= col_q + 3'd1;
              fb_we_q   <= nxt_we;
              fb_addr_q <= nxt_addr;
              fb_data_q <= nxt_data;
            end
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_data   = fb_data_q;
  assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_note_glyph_blitter.sv
// tb_note_glyph_blitter
//   Self-checking bench for note_glyph_blitter. Holds the glyph ROM, drives
//   draw commands and frame-buffer backpressure, and compares every accepted
//   write and the done timing against a pixel-list model built directly from
//   the glyph geometry. Honours NOTE_BLIT_OPAQUE_EN when compiled with it.
module tb_note_glyph_blitter;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int FB_ADDR_W = 19;
  localparam int COLOR_W   = 4;
`ifdef NOTE_BLIT_OPAQUE_EN
  localparam bit OPAQUE = 1'b1;
`else
  localparam bit OPAQUE = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_code;
  logic [9:0]           cmd_x;
  logic [9:0]           cmd_y;
  logic [COLOR_W-1:0]   cmd_fg;
  logic [COLOR_W-1:0]   cmd_bg;
  logic [5:0]           rom_addr;
  logic [7:0]           rom_data;
  logic                 fb_we;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [COLOR_W-1:0]   fb_data;
  logic                 fb_ready;
  logic                 busy;
  logic                 done;

  note_glyph_blitter #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
    .FB_ADDR_W(FB_ADDR_W), .COLOR_W(COLOR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_fg(cmd_fg), .cmd_bg(cmd_bg),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:63];
  assign rom_data = rom[rom_addr];

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [COLOR_W-1:0]   data;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  checks = 0;
  int  failures = 0;
  int  last_done_n;
  int  last_stalls;

  // Expected write list: every pixel of the glyph in raster order that is on
  // screen and (set, or opaque mode).
  task automatic build_expected(input int code, input int x, input int y,
                                input int fg, input int bg);
    exp_q.delete();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        logic [7:0] rb;
        bit         b;
        int         px, py;
        wr_t        w;
        rb = rom[code*8 + r];
        b  = rb[7-c];
        px = x + c;
        py = y + r;
        if (px < SCREEN_W && py < SCREEN_H && (b || OPAQUE)) begin
          w.addr = FB_ADDR_W'(py*SCREEN_W + px);
          w.data = b ? COLOR_W'(fg) : COLOR_W'(bg);
          exp_q.push_back(w);
        end
      end
    end
  endtask

  // Issue one command and follow it to done. stall_first holds fb_ready low
  // for that many cycles on the first write; rand_bp adds random stalls.
  task automatic run_cmd(input int code, input int x, input int y, input int fg,
                         input int bg, input int stall_first, input bit rand_bp);
    int  n, stalls, wait_n, done_n, stall_left;
    bit  first_pending, prev_stall, go_low;
    wr_t w, e, held;
    build_expected(code, x, y, fg, bg);
    obs_q.delete();
    @(negedge clk);
    fb_ready  = 1'b1;
    cmd_code  = 3'(code);
    cmd_x     = 10'(x);
    cmd_y     = 10'(y);
    cmd_fg    = COLOR_W'(fg);
    cmd_bg    = COLOR_W'(bg);
    cmd_valid = 1'b1;
    wait_n = 0;
    while (!cmd_ready && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait: cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Busy now: scramble the command bus, which must be ignored.
    cmd_code = 3'($urandom);
    cmd_x    = 10'($urandom);
    cmd_y    = 10'($urandom);
    cmd_fg   = COLOR_W'($urandom);
    cmd_bg   = COLOR_W'($urandom);
    n = 1; stalls = 0; done_n = -1; stall_left = stall_first;
    first_pending = 1'b1; prev_stall = 1'b0; held = '0;
    while (n <= 1000) begin
      if (done) begin
        done_n = n;
        break;
      end
      if (fb_we) begin
        w.addr = fb_addr;
        w.data = fb_data;
        if (prev_stall) begin
          checks++;
          if (w !== held) begin
            failures++;
            $display("FAIL stall_hold: addr=%0d data=%h required addr=%0d data=%h",
                     w.addr, w.data, held.addr, held.data);
          end
        end
        go_low = (first_pending && stall_left > 0) ||
                 (rand_bp && $urandom_range(0, 2) == 0);
        if (go_low) begin
          fb_ready = 1'b0;
          stalls++;
          prev_stall = 1'b1;
          held = w;
          if (first_pending) stall_left--;
        end else begin
          fb_ready = 1'b1;
          prev_stall = 1'b0;
          first_pending = 1'b0;
          obs_q.push_back(w);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_write: addr=%0d data=%h required no write", w.addr, w.data);
          end else begin
            e = exp_q.pop_front();
            if (w !== e) begin
              failures++;
              $display("FAIL write: addr=%0d data=%h required addr=%0d data=%h",
                       w.addr, w.data, e.addr, e.data);
            end
          end
        end
      end else begin
        if (prev_stall) begin
          checks++;
          failures++;
          $display("FAIL stall_drop: fb_we=0 required 1 while stalled");
        end
        prev_stall = 1'b0;
        fb_ready = 1'($urandom_range(0, 1));
      end
      cmd_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    last_done_n = done_n;
    last_stalls = stalls;
    checks++;
    if (done_n != 73 + stalls) begin
      failures++;
      $display("FAIL done_timing: cycle=%0d required %0d", done_n, 73 + stalls);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes: %0d writes missing required 0", exp_q.size());
    end
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1 || fb_we !== 1'b0) begin
      failures++;
      $display("FAIL done_state: ready=%b busy=%b we=%b required 0 1 0", cmd_ready, busy, fb_we);
    end
    @(negedge clk);
    fb_ready = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL post_done: ready=%b busy=%b done=%b required 1 0 0", cmd_ready, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; fb_ready = 1'b1;
    cmd_code = '0; cmd_x = '0; cmd_y = '0; cmd_fg = '0; cmd_bg = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
    checks++;
    if (fb_we !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses: we=%b done=%b required 0 0", fb_we, done);
    end
    checks++;
    if (rom_addr !== 6'd0 || fb_addr !== '0 || fb_data !== '0) begin
      failures++;
      $display("FAIL reset_regs: rom=%0d addr=%0d data=%h required 0 0 0",
               rom_addr, fb_addr, fb_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_quarter();
    int hits;
    run_cmd(1, 100, 50, 4'hA, 4'h3, 0, 1'b0);
    checks++;
    if (obs_q.size() != (OPAQUE ? 64 : 20)) begin
      failures++;
      $display("FAIL quarter_count: %0d writes required %0d", obs_q.size(), OPAQUE ? 64 : 20);
    end
    hits = 0;
    foreach (obs_q[i]) begin
      if ((obs_q[i].addr == 19'd32743 || obs_q[i].addr == 19'd32744) && obs_q[i].data == 4'hA)
        hits++;
    end
    checks++;
    if (hits != 2) begin
      failures++;
      $display("FAIL quarter_row1: %0d hits required 2", hits);
    end
  endtask

  task automatic test_blank();
    run_cmd(0, 200, 100, 4'h7, 4'h2, 0, 1'b0);
    checks++;
    if (obs_q.size() != (OPAQUE ? 64 : 0)) begin
      failures++;
      $display("FAIL blank_count: %0d writes required %0d", obs_q.size(), OPAQUE ? 64 : 0);
    end
  endtask

  task automatic test_clip();
    int max_addr;
    run_cmd(3, 636, 476, 4'h5, 4'h2, 0, 1'b0);
    checks++;
    if (obs_q.size() != (OPAQUE ? 16 : 6)) begin
      failures++;
      $display("FAIL clip_count: %0d writes required %0d", obs_q.size(), OPAQUE ? 16 : 6);
    end
    max_addr = 0;
    foreach (obs_q[i]) if (int'(obs_q[i].addr) > max_addr) max_addr = int'(obs_q[i].addr);
    checks++;
    if (max_addr >= 307200) begin
      failures++;
      $display("FAIL clip_addr: max addr=%0d required below 307200", max_addr);
    end
    run_cmd(1, 100, 480, 4'h5, 4'h2, 0, 1'b0);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL clip_y: %0d writes required 0", obs_q.size());
    end
    run_cmd(7, 1023, 10, 4'h5, 4'h2, 0, 1'b0);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL clip_nowrap: %0d writes required 0", obs_q.size());
    end
  endtask

  task automatic test_stall();
    run_cmd(1, 100, 50, 4'hA, 4'h3, 5, 1'b0);
    checks++;
    if (last_stalls != 5 || last_done_n != 78) begin
      failures++;
      $display("FAIL stall_delay: stalls=%0d done=%0d required 5 78", last_stalls, last_done_n);
    end
  endtask

  task automatic test_abort();
    int n, bad;
    @(negedge clk);
    fb_ready = 1'b1;
    cmd_code = 3'd1; cmd_x = 10'd100; cmd_y = 10'd50; cmd_fg = 4'hA; cmd_bg = 4'h3;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || fb_we !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: ready=%b busy=%b we=%b done=%b required 1 0 0 0",
               cmd_ready, busy, fb_we, done);
    end
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (fb_we || done || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_quiet: %0d active cycles required 0", bad);
    end
    run_cmd(1, 100, 50, 4'hA, 4'h3, 0, 1'b0);
  endtask

`ifdef NOTE_BLIT_OPAQUE_EN
  task automatic test_opaque();
    logic [3:0] want;
    int         bad;
    run_cmd(6, 0, 0, 4'hF, 4'h1, 0, 1'b0);
    checks++;
    if (obs_q.size() != 64) begin
      failures++;
      $display("FAIL opaque_count: %0d writes required 64", obs_q.size());
    end else begin
      bad = 0;
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          if (r == 5) want = 4'hF;
          else if (r == 3) want = (c == 0 || c == 7) ? 4'h1 : 4'hF;
          else want = 4'h1;
          if (obs_q[r*8+c].addr !== 19'(r*640 + c) || obs_q[r*8+c].data !== want) bad++;
        end
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL opaque_pixels: %0d wrong pixels required 0", bad);
      end
    end
  endtask
`endif

  task automatic test_random();
    int x, y;
    for (int k = 0; k < 25; k++) begin
      x = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1023) : $urandom_range(0, 640);
      y = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1023) : $urandom_range(0, 480);
      run_cmd($urandom_range(0, 7), x, y, $urandom_range(0, 15), $urandom_range(0, 15),
              0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    fb_ready = 1'b1;
    cmd_code = 3'd0; cmd_x = 10'd10; cmd_y = 10'd10; cmd_fg = 4'h9; cmd_bg = 4'h4;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    // Second command held from the first busy cycle onwards.
    cmd_code = 3'd2; cmd_x = 10'd20; cmd_y = 10'd30;
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 73 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first_done: cycle=%0d ready=%b required 73 0", n, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || rom_addr !== 6'd16) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b rom_addr=%0d required 1 16", busy, rom_addr);
    end
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 73) begin
      failures++;
      $display("FAIL b2b_second_done: cycle=%0d required 73", n);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    for (int r = 0; r < 8; r++) rom[r] = 8'h00;
    // Quarter note: 20 set bits, row 1 at columns 3 and 4.
    rom[8]  = 8'h08; rom[9]  = 8'h18; rom[10] = 8'h08; rom[11] = 8'h18;
    rom[12] = 8'h78; rom[13] = 8'h78; rom[14] = 8'h78; rom[15] = 8'h30;
    // Whole note.
    rom[24] = 8'h00; rom[25] = 8'h3C; rom[26] = 8'h66; rom[27] = 8'hC3;
    rom[28] = 8'hC3; rom[29] = 8'h66; rom[30] = 8'h3C; rom[31] = 8'h00;
    // Half rest.
    rom[48] = 8'h00; rom[49] = 8'h00; rom[50] = 8'h00; rom[51] = 8'h7E;
    rom[52] = 8'h00; rom[53] = 8'hFF; rom[54] = 8'h00; rom[55] = 8'h00;

    test_reset();
    test_quarter();
    test_blank();
    test_clip();
    test_stall();
    test_abort();
`ifdef NOTE_BLIT_OPAQUE_EN
    test_opaque();
`endif
    test_back_to_back();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_glyph_blitter.md
Name: note_glyph_blitter

Overview:
- Reads 8x8 note/rest glyphs from `note_rom` and writes them pixel-by-pixel into the staff frame buffer at a commanded screen position.
- Sits between the score/sequencer logic, which issues draw commands, and the frame-buffer write port.
- Accepts one command at a time over a valid/ready handshake and pulses `done` when the glyph is finished.
- Clips pixels that fall off-screen; honours frame-buffer backpressure.

Parameters:
- SCREEN_W, 640, visible width in pixels; also the frame-buffer row pitch.
- SCREEN_H, 480, visible height in pixels.
- FB_ADDR_W, 19, frame-buffer address width.
- COLOR_W, 4, palette-index width.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  draw command present.
- cmd_ready  out  1  block can accept a command.
- cmd_code  in  3  glyph code, 0x0–0x7 (blank, quarter, half, whole, eighth rest, quarter rest, half rest, whole rest).
- cmd_x  in  10  left column of the glyph.
- cmd_y  in  10  top row of the glyph.
- cmd_fg  in  COLOR_W  colour for set bits.
- cmd_bg  in  COLOR_W  colour for clear bits; used only with the optional feature.
- rom_addr  out  6  `note_rom` address; `{code, row}`.
- rom_data  in  8  `note_rom` row data, combinational from `rom_addr`.
- fb_we  out  1  frame-buffer write strobe.
- fb_addr  out  FB_ADDR_W  write address = py*SCREEN_W + px.
- fb_data  out  COLOR_W  write colour.
- fb_ready  in  1  frame buffer accepts the write this cycle.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when the glyph is complete.

Behaviour:
- Reset values:
  - State IDLE, so `cmd_ready` = 1 and `busy` = 0.
  - `fb_we`, `done` = 0.
  - `rom_addr`, `fb_addr`, `fb_data` = 0.
  - Row and column counters = 0.
- A reset mid-glyph aborts the command: no further writes and no `done` pulse.
- State machine: IDLE → FETCH → DRAW → (FETCH | DONE) → IDLE.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready`, latch code, x, y, fg, bg; set row = 0; go to FETCH.
  - `cmd_*` inputs are ignored while busy.
- FETCH (1 cycle):
  - `rom_addr = {code, row}`.
  - At the end of the cycle, latch `rom_data` into the row register, set col = 0, go to DRAW.
- DRAW (handles one pixel per cycle):
  - Pixel bit = `rowreg[7-col]`; bit 7 is the leftmost pixel.
  - px = x + col and py = y + row, each computed 11 bits wide.
  - The pixel is visible iff px < SCREEN_W and py < SCREEN_H.
  - `fb_we` = 1 iff the pixel is visible and the bit is set; with NOTE_BLIT_OPAQUE_EN, also for a visible clear bit.
  - `fb_data` = fg for a set bit, bg for a clear bit.
  - `fb_addr` = py*SCREEN_W + px, implemented as shifts and adds, truncated to FB_ADDR_W.
  - `fb_we`, `fb_addr`, `fb_data` are registered outputs: they describe the pixel currently being handled and are valid in the same DRAW cycle.
- Advance and stall rules in DRAW:
  - The column advances when no write is needed, or when `fb_we & fb_ready`.
  - If a write is needed and `fb_ready` = 0: hold col; hold `fb_we`, `fb_addr`, `fb_data` stable.
  - At col = 7 with advance: if row = 7, go to DONE; else increment row and go to FETCH.
- DONE (1 cycle): `done` = 1, `busy` = 1, `cmd_ready` = 0; next state IDLE.
- Timing with no backpressure:
  - 8 rows × (1 FETCH + 8 DRAW) = 72 cycles after the accept edge.
  - `done` is high in the 73rd cycle; `cmd_ready` is high again in the 74th.
- Code 0 (blank), transparent mode: zero writes, same timing.
- Clipping: x = 636 draws cols 0–3 only; y ≥ 480 writes nothing. Timing is unchanged in both cases.
- No arithmetic wraps: 1023 + 7 is evaluated in 11 bits and clips.
- Back-to-back commands: a command presented during DONE is not accepted; it is accepted in the following IDLE cycle.

Optional Feature:
- Macro: NOTE_BLIT_OPAQUE_EN.
- Defined: clear bits of visible pixels also write `cmd_bg`, so 64 writes per fully visible glyph. Stalls apply to every write.
- Undefined: transparent mode; clear bits never write; `cmd_bg` is unused.

Test Plan:
- Reset, then cmd code=1, x=100, y=50, fg=0xA → writes only at the set bits of the quarter glyph (20 writes total). Row 1 writes fb_addr 51*640+103 = 32743 and 32744 with data 0xA. `done` pulses exactly 73 cycles after accept.
- cmd code=0 → zero `fb_we` cycles; `done` at cycle 73.
- cmd code=3, x=636, y=476 → only pixels with px < 640 and py < 480 are written: rows 0–3, cols 0–3, set bits only. No address ≥ 307200 appears.
- Same as the first scenario with `fb_ready` held low for 5 cycles on the first write → `fb_we`, `fb_addr`, `fb_data` stable across the stall; `done` delayed by exactly 5 cycles; write sequence unchanged.
- Reset asserted 30 cycles into a glyph → next cycle is IDLE with `cmd_ready` = 1, `fb_we` = 0, no `done`; a new command then completes normally.
- With NOTE_BLIT_OPAQUE_EN, cmd code=6, x=0, y=0, fg=0xF, bg=0x1 → 64 writes, addresses row*640+col. Row 5 is all 0xF; row 3 is 0x1,0xF×6,0x1; rows 0–2 and 6–7 are all 0x1.
